// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmitter: FSM state encoding and frame constants.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } UartTxState;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte write port from the memory access stage plus transmitter status flags.
interface uart_tx_if;
  logic [7:0] uart;
  logic       uartWe;
  logic       busy;
  logic       full;
  logic       overflow;

  modport master (output uart, uartWe, input busy, full, overflow);
  modport slave  (input uart, uartWe, output busy, full, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; a push to a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter draining the pipeline's byte write port onto txd.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH byte buffer; otherwise a single holding register.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  wr,
  output logic      txd
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  localparam int unsigned BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BaudEnd = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastBit   = 3'(UART_FRAME_BITS - 3);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          overflow_q;

  logic          pop, push;
  logic          buf_empty, buf_full, buf_nonempty;
  logic [7:0]    buf_rdata;

  assign push = wr.uartWe && (!buf_full || pop);

`ifdef UART_TX_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] buf_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr.uart),
    .rdata (buf_rdata),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign buf_nonempty = (buf_count != '0);
`else
  logic [7:0]  hold_q;
  logic        hold_valid_q;
  logic [31:0] unused_fifo_depth;

  assign unused_fifo_depth = FIFO_DEPTH;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (push) begin
      hold_q       <= wr.uart;
      hold_valid_q <= 1'b1;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign buf_rdata    = hold_q;
  assign buf_full     = hold_valid_q;
  assign buf_empty    = !hold_valid_q;
  assign buf_nonempty = hold_valid_q;
`endif

  // Baud counter restarts on every state entry so frames never drift.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!buf_empty) begin
          pop     = 1'b1;
          shift_d = buf_rdata;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == BaudEnd) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_q == BaudEnd) begin
          baud_d = '0;
          if (bit_q == LastBit) begin
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      default: begin
        if (baud_q == BaudEnd) begin
          baud_d = '0;
          if (!buf_empty) begin
            pop     = 1'b1;
            shift_d = buf_rdata;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    // Output level follows the next state so txd stays a clean flop output.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= UART_IDLE_LEVEL;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_q | (wr.uartWe && !push);
    end
  end

  assign txd         = txd_q;
  assign wr.busy     = (state_q != ST_IDLE) || buf_nonempty;
  assign wr.full     = buf_full;
  assign wr.overflow = overflow_q;

endmodule
